wordcopy_dma: RTL and testbench

- Parametrised successor to the single-channel word copier: Avalon-MM slave for CPU control, Avalon-MM master onto system memory.
- Copies COUNT words from SRC to DST with a programmable source stride and pipelined reads (multiple outstanding, readdatavalid-driven).
- Adds a fill mode that writes a constant without reading.
- Sits beside the CPU on the interconnect; the CPU blocks on the start write until the transfer completes.

---
 rtl/wordcopy_pkg.sv | 13 +
 rtl/wordcopy_fifo.sv | 43 ++++
 rtl/wordcopy_dma.sv | 143 ++++++++++++++
 tb/tb_wordcopy_dma.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wordcopy_pkg.sv
// wordcopy_pkg: register map, FSM state type and MODE bit for the word-copy DMA
package wordcopy_pkg;
    localparam logic [3:0] REG_START    = 4'd0;
    localparam logic [3:0] REG_DST      = 4'd1;
    localparam logic [3:0] REG_SRC      = 4'd2;
    localparam logic [3:0] REG_COUNT    = 4'd3;
    localparam logic [3:0] REG_STRIDE   = 4'd4;
    localparam logic [3:0] REG_FILL     = 4'd5;
    localparam logic [3:0] REG_MODE     = 4'd6;
    localparam logic [3:0] REG_DONE_CNT = 4'd7;
    localparam int MODE_FILL_BIT = 0;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/wordcopy_fifo.sv
// wordcopy_fifo: synchronous read-data FIFO between master read responses and writes
// Ports: i_push/i_data enqueue, i_pop dequeues o_data (head, show-ahead), o_full/o_empty/o_count status.
module wordcopy_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_cnt;
    logic             w_push, w_pop;
    assign o_count = r_cnt;
    assign o_empty = r_cnt == '0;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_data  = r_mem[r_rp];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    assert property (@(posedge clk) disable iff (rst) !(i_push && o_full && !i_pop));
endmodule

// File: rtl/wordcopy_dma.sv
// wordcopy_dma: strided word copy / constant fill DMA with an Avalon-MM slave and pipelined Avalon-MM master
// Ports: slave_* is the CPU register port (start write stalls until done), master_* drives system memory
// with up to MAX_OUT outstanding in-order reads; clk/rst are the clock and synchronous active-high reset.
module wordcopy_dma
    import wordcopy_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int COUNT_W = 16,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [DATA_W-1:0] slave_writedata,
    output logic [DATA_W-1:0] slave_readdata,
    output logic              slave_waitrequest,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    input  logic              master_waitrequest
);
    localparam int OW = $clog2(MAX_OUT) + 1;
    state_t            r_state;
    logic [ADDR_W-1:0] r_dst, r_src, r_stride, r_rd_ptr, r_wr_ptr;
    logic [COUNT_W-1:0] r_count, r_rd_cnt, r_wr_cnt, r_done_cnt;
    logic [DATA_W-1:0] r_fill, w_fdata, w_rdata;
    logic              r_fill_mode, r_done;
    logic [OW-1:0]     r_out, w_fcnt;
    logic [OW:0]       w_occ;
    logic              w_fempty, w_ffull, w_push, w_pop;
    logic              w_busy, w_active, w_start, w_rd_acc, w_wr_acc, w_free;
    logic              w_rd_ok, w_wr_ok, w_last, w_issued;
    assign w_busy   = r_state != S_IDLE;
    assign w_active = r_state == S_RUN || r_state == S_DRAIN;
    assign w_start  = r_state == S_IDLE && slave_write && slave_address == REG_START;
    assign slave_waitrequest = w_start || w_active;
    assign w_rd_acc = master_read && !master_waitrequest;
    assign w_wr_acc = master_write && !master_waitrequest;
    // A new request may be loaded when nothing is presented or the presented one is accepted now.
    assign w_free   = !(master_read || master_write) || !master_waitrequest;
    assign w_push   = w_active && master_readdatavalid;
    // Credit: reads in flight (including one accepted this cycle) plus buffered words.
    assign w_occ    = {1'b0, r_out} + {{OW{1'b0}}, w_rd_acc} + {1'b0, w_fcnt};
    assign w_wr_ok  = w_active && (r_fill_mode ? r_wr_cnt != r_count : !w_fempty);
    assign w_rd_ok  = w_active && !r_fill_mode && r_rd_cnt != r_count && w_occ < (OW+1)'(MAX_OUT);
    assign w_pop    = w_free && w_wr_ok && !r_fill_mode;
    assign w_last   = r_done_cnt + COUNT_W'(w_wr_acc) == r_count;
    assign w_issued = r_fill_mode ? r_wr_cnt == r_count : r_rd_cnt == r_count;
    wordcopy_fifo #(.DEPTH(MAX_OUT), .WIDTH(DATA_W)) u_fifo (
        .clk(clk), .rst(rst), .i_push(w_push), .i_data(master_readdata), .i_pop(w_pop),
        .o_data(w_fdata), .o_full(w_ffull), .o_empty(w_fempty), .o_count(w_fcnt)
    );
    assert property (@(posedge clk) disable iff (rst) !(w_push && w_ffull && !w_pop));
    always_comb begin
        w_rdata = '0;
        case (slave_address)
            REG_START:    w_rdata = DATA_W'({w_busy, r_done});
            REG_DST:      w_rdata = DATA_W'(r_dst);
            REG_SRC:      w_rdata = DATA_W'(r_src);
            REG_COUNT:    w_rdata = DATA_W'(r_count);
            REG_STRIDE:   w_rdata = DATA_W'(r_stride);
            REG_FILL:     w_rdata = r_fill;
            REG_MODE:     w_rdata = DATA_W'(r_fill_mode);
            REG_DONE_CNT: w_rdata = DATA_W'(r_done_cnt);
            default:      w_rdata = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_dst            <= '0;
            r_src            <= '0;
            r_stride         <= '0;
            r_rd_ptr         <= '0;
            r_wr_ptr         <= '0;
            r_count          <= '0;
            r_rd_cnt         <= '0;
            r_wr_cnt         <= '0;
            r_done_cnt       <= '0;
            r_fill           <= '0;
            r_fill_mode      <= 1'b0;
            r_done           <= 1'b0;
            r_out            <= '0;
            slave_readdata   <= '0;
            master_address   <= '0;
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_writedata <= '0;
        end else begin
            if (slave_read) slave_readdata <= w_rdata;
            if (r_state == S_IDLE && slave_write)
                case (slave_address)
                    REG_DST:    r_dst       <= ADDR_W'(slave_writedata);
                    REG_SRC:    r_src       <= ADDR_W'(slave_writedata);
                    REG_COUNT:  r_count     <= COUNT_W'(slave_writedata);
                    REG_STRIDE: r_stride    <= ADDR_W'(slave_writedata);
                    REG_FILL:   r_fill      <= slave_writedata;
                    REG_MODE:   r_fill_mode <= slave_writedata[MODE_FILL_BIT];
                    default: ;
                endcase
            // Requests are counted and pointers advanced at issue; issued requests are held until accepted.
            if (w_free) begin
                master_read  <= !w_wr_ok && w_rd_ok;
                master_write <= w_wr_ok;
                if (w_wr_ok) begin
                    master_address   <= r_wr_ptr;
                    master_writedata <= r_fill_mode ? r_fill : w_fdata;
                    r_wr_ptr         <= r_wr_ptr + ADDR_W'(4);
                    r_wr_cnt         <= r_wr_cnt + COUNT_W'(1);
                end else if (w_rd_ok) begin
                    master_address <= r_rd_ptr;
                    r_rd_ptr       <= r_rd_ptr + (r_stride << 2);
                    r_rd_cnt       <= r_rd_cnt + COUNT_W'(1);
                end
            end
            if (w_active) r_out <= r_out + OW'(w_rd_acc) - OW'(master_readdatavalid);
            if (w_wr_acc) r_done_cnt <= r_done_cnt + COUNT_W'(1);
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_state    <= S_RUN;
                    r_rd_cnt   <= '0;
                    r_wr_cnt   <= '0;
                    r_done_cnt <= '0;
                    r_rd_ptr   <= r_src;
                    r_wr_ptr   <= r_dst;
                    r_done     <= 1'b0;
                end
                S_RUN:   r_state <= w_last ? S_DONE : w_issued ? S_DRAIN : S_RUN;
                S_DRAIN: if (w_last) r_state <= S_DONE;
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wordcopy_dma.sv
// tb_wordcopy_dma: randomized scoreboard bench for wordcopy_dma with an in-order latency memory model
module tb_wordcopy_dma;
    localparam int MAX_OUT = 4;
    logic        clk = 0, rst = 1;
    logic [3:0]  slave_address = 0;
    logic        slave_read = 0, slave_write = 0;
    logic [31:0] slave_writedata = 0, slave_readdata;
    logic        slave_waitrequest;
    logic [31:0] master_address, master_writedata, master_readdata = 0;
    logic        master_read, master_write;
    logic        master_readdatavalid = 0, master_waitrequest = 0;
    int n_tests = 0, n_fail = 0;
    typedef struct { int t; logic [31:0] d; } rsp_t;
    rsp_t        rq[$];
    logic [31:0] exp_rd[$];
    logic [63:0] exp_wr[$];
    logic [31:0] seed = 0;
    int lat = 2, bp = 0, cyc = 0, tb_out = 0, max_out = 0;
    int reads_seen = 0, writes_seen = 0, rel_writes = 0, wr_cycles = 0;
    logic        prev_stall = 0, prev_rd = 0, prev_wr = 0;
    logic [31:0] prev_a = 0, prev_d = 0;

    always #5 clk = ~clk;

    wordcopy_dma dut (
        .clk(clk), .rst(rst),
        .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
        .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
        .slave_waitrequest(slave_waitrequest),
        .master_address(master_address), .master_read(master_read), .master_write(master_write),
        .master_writedata(master_writedata), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid), .master_waitrequest(master_waitrequest)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a * 32'h9E3779B9) ^ seed;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Memory, backpressure and monitor: decides this cycle's waitrequest, so it knows which
    // request the DUT will see accepted at the next rising edge.
    always @(negedge clk) begin
        logic wreq;
        rsp_t r;
        cyc++;
        wreq = (bp != 0) && ($urandom_range(0, 1) == 1);
        master_waitrequest = wreq;
        if (rq.size() != 0 && rq[0].t <= cyc) begin
            r = rq.pop_front();
            master_readdatavalid = 1;
            master_readdata = r.d;
            if (tb_out > 0) tb_out--;
        end else begin
            master_readdatavalid = 0;
        end
        if (rst) begin
            prev_stall = 0;
            tb_out = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_addr_data", {master_address, master_writedata}, {prev_a, prev_d});
                chk("hold_strobes", {62'd0, master_read, master_write}, {62'd0, prev_rd, prev_wr});
            end
            if (master_read && master_write) begin
                n_tests++;
                n_fail++;
                $display("FAIL read_and_write_together at addr 0x%0h", master_address);
            end
            if (master_read && !wreq) begin
                reads_seen++;
                tb_out++;
                if (tb_out > max_out) max_out = tb_out;
                if (exp_rd.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_read: got addr 0x%0h, expected no read", master_address);
                end else chk("read_addr", {32'd0, master_address}, {32'd0, exp_rd.pop_front()});
                rq.push_back('{cyc + lat, mem_val(master_address)});
            end
            if (master_write && !wreq) begin
                writes_seen++;
                if (exp_wr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             master_address, master_writedata);
                end else chk("write_addr_data", {master_address, master_writedata}, exp_wr.pop_front());
            end
            prev_stall = (master_read || master_write) && wreq;
            prev_rd = master_read;
            prev_wr = master_write;
            prev_a = master_address;
            prev_d = master_writedata;
        end
    end

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        bit acc = 0;
        slave_address = a;
        slave_writedata = d;
        slave_write = 1;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(negedge clk);
            acc = !slave_waitrequest;
            if (acc) begin
                wr_cycles = i + 1;
                rel_writes = writes_seen;
            end
            @(posedge clk);
            #1;
        end
        slave_write = 0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL write_timeout: reg %0d still stalled, expected completion", a);
        end
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [31:0] d);
        slave_address = a;
        slave_read = 1;
        @(posedge clk);
        #1;
        slave_read = 0;
        d = slave_readdata;
    endtask

    task automatic setup(input logic [31:0] dst, input logic [31:0] src, input int cnt,
                         input logic [31:0] stride, input bit fill, input logic [31:0] fv);
        logic [31:0] k4;
        seed = $urandom;
        wr_reg(1, dst);
        wr_reg(2, src);
        wr_reg(3, 32'(cnt));
        wr_reg(4, stride);
        wr_reg(5, fv);
        wr_reg(6, {31'd0, fill});
        exp_rd.delete();
        exp_wr.delete();
        for (int k = 0; k < cnt; k++) begin
            k4 = 32'(k) * 4;
            if (!fill) exp_rd.push_back(src + k4 * stride);
            exp_wr.push_back({dst + k4, fill ? fv : mem_val(src + k4 * stride)});
        end
        reads_seen = 0;
        writes_seen = 0;
        max_out = 0;
        tb_out = 0;
    endtask

    task automatic run(input logic [31:0] dst, input logic [31:0] src, input int cnt,
                       input logic [31:0] stride, input bit fill, input logic [31:0] fv,
                       input int l, input int b);
        logic [31:0] r;
        lat = l;
        setup(dst, src, cnt, stride, fill, fv);
        bp = b;
        wr_reg(0, 0);
        bp = 0;
        chk("writes_before_release", 64'(rel_writes), 64'(cnt));
        chk("expected_writes_left", 64'(exp_wr.size()), 0);
        chk("read_count", 64'(reads_seen), fill ? 0 : 64'(cnt));
        chk("max_outstanding_ok", {63'd0, max_out <= MAX_OUT}, 1);
        rd_reg(7, r);
        chk("done_cnt", {32'd0, r}, 64'(cnt));
        rd_reg(0, r);
        chk("start_status", {32'd0, r}, 1);
    endtask

    initial begin
        logic [31:0] r;
        bit hit;
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        bit hit;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {30'd0, master_read, master_write, master_address},
            {30'd0, 2'b00, 32'd0});
        chk("reset_wdata_wait", {31'd0, slave_waitrequest, master_writedata}, 0);
        rst = 0;
        rd_reg(0, r);
        chk("reset_start_reg", {32'd0, r}, 0);
        rd_reg(7, r);
        chk("reset_done_cnt", {32'd0, r}, 0);
        rd_reg(12, r);
        chk("unmapped_read", {32'd0, r}, 0);

        run(32'h400, 32'h100, 8, 1, 0, 0, 2, 0);
        run(32'h600, 32'h0, 4, 3, 0, 0, 2, 0);
        run(32'h200, 32'h1000, 5, 1, 1, 32'hDEADBEEF, 2, 0);
        run(32'h2000, 32'h3000, 16, 1, 0, 0, 2, 1);
        run(32'h500, 32'h100, 0, 1, 0, 0, 2, 0);
        chk("count0_release_cycles", {63'd0, wr_cycles <= 3}, 1);
        run(32'hFFFF_FFF8, 32'hFFFF_FFF0, 4, 2, 0, 0, 3, 1);

        lat = 2;
        setup(32'h700, 32'h40, 16, 1, 0, 0);
        slave_address = 0;
        slave_writedata = 0;
        slave_write = 1;
        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = writes_seen >= 3;
        end
        if (!hit) begin
            n_tests++;
            n_fail++;
            $display("FAIL reset_wait_timeout: got %0d writes, expected 3", writes_seen);
        end
        rst = 1;
        slave_write = 0;
        @(posedge clk);
        #1;
        chk("strobes_after_reset", {62'd0, master_read, master_write}, 0);
        rst = 0;
        exp_rd.delete();
        exp_wr.delete();
        rd_reg(0, r);
        chk("start_after_reset", {32'd0, r}, 0);
        rd_reg(3, r);
        chk("count_after_reset", {32'd0, r}, 0);
        rd_reg(7, r);
        chk("done_cnt_after_reset", {32'd0, r}, 0);
        rq.delete();
        run(32'h900, 32'h80, 2, 1, 0, 0, 2, 0);

        for (int i = 0; i < 6; i++)
            run($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom_range(1, 12),
                32'($urandom_range(0, 4)), $urandom_range(0, 3) == 0, $urandom,
                $urandom_range(1, 3), $urandom_range(0, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
